// File: rtl/plank_cmd_master.sv
// Purpose : Serialises one 19-byte plank command over a byte UART, then waits for a matching
//           feedback frame; assembles 3-byte RX frames into feedback or telemetry results.
// Latency : one TX strobe per byte once the UART is idle; fb/telemetry pulses 1 cycle after the 3rd RX byte.
// Backpressure: o_cmd_ready only in IDLE; each byte waits for i_uart_tx_active low and i_uart_tx_done.
// Ports   : i_clk/i_rst clock and async reset; i_cmd_* command handshake and payload;
//           o_uart_tx_* / i_uart_tx_* byte TX handshake; i_uart_rx_* received bytes;
//           o_fb_* feedback result; o_telem_* telemetry frames.
module plank_cmd_master #(
    parameter logic [7:0]  HEADER     = 8'h02,
    parameter int unsigned FB_TIMEOUT = 200000,
    parameter int unsigned GAP_CYCLES = 2000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_tx_rx_sel,
    input  logic        i_soft_inhibit,
    input  logic [47:0] i_phase,
    input  logic [47:0] i_attn,
    input  logic [7:0]  i_ch_power,
    output logic        o_uart_tx_valid,
    output logic [7:0]  o_uart_tx_data,
    input  logic        i_uart_tx_active,
    input  logic        i_uart_tx_done,
    input  logic        i_uart_rx_valid,
    input  logic [7:0]  i_uart_rx_data,
    output logic        o_fb_valid,
    output logic        o_fb_match,
    output logic        o_fb_timeout,
    output logic        o_telem_valid,
    output logic [23:0] o_telem_data
);

    localparam int unsigned FB_W  = $clog2(FB_TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [FB_W-1:0]  FB_LAST  = FB_W'(FB_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_WAIT_FB   = 2'd3;

    localparam logic [4:0] LAST_IDX = 5'd18;
    localparam logic [7:0] FB_TAG   = 8'hEE;

    logic [1:0]       state;
    logic [4:0]       idx;
    logic [FB_W-1:0]  fb_cnt;

    // Command fields captured at acceptance; the packet is built from these only.
    logic             sel_l;
    logic             inh_l;
    logic [47:0]      phase_l;
    logic [47:0]      attn_l;
    logic [7:0]       power_l;

    // RX frame assembler
    logic [1:0]       rx_cnt;
    logic [7:0]       rx_b0;
    logic [7:0]       rx_b1;
    logic [GAP_W-1:0] gap_cnt;

    logic             frame_done;
    logic [23:0]      frame;
    logic             is_fb;
    logic             is_telem;

    logic [5:0]       phase_ch [8];
    logic [5:0]       attn_ch  [8];
    logic [4:0]       pair;
    logic [7:0]       cur_byte;

    assign o_cmd_ready = (state == ST_IDLE);

    assign frame_done = i_uart_rx_valid && (rx_cnt == 2'd2);
    assign frame      = {i_uart_rx_data, rx_b1, rx_b0};
    assign is_fb      = frame_done && (rx_b0 == FB_TAG) && (state == ST_WAIT_FB);
    // Feedback-tagged frames outside WAIT_FB are dropped rather than reported as telemetry.
    assign is_telem   = frame_done && (rx_b0 != FB_TAG);

    // Byte select: idx 2..17 alternate phase/attn for channels 1..8.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            phase_ch[k] = phase_l[6*k +: 6];
            attn_ch[k]  = attn_l[6*k +: 6];
        end
        pair     = idx - 5'd2;
        cur_byte = 8'h00;
        if (idx == 5'd0) begin
            cur_byte = HEADER;
        end else if (idx == 5'd1) begin
            cur_byte = {4'b0000, inh_l, sel_l, 2'b00};
        end else if (idx == LAST_IDX) begin
            cur_byte = power_l;
        end else if (!pair[0]) begin
            cur_byte = {2'b00, phase_ch[pair[3:1]]};
        end else begin
            cur_byte = {2'b00, attn_ch[pair[3:1]]};
        end
    end

    // RX assembler: runs regardless of FSM state; a stalled partial frame is flushed
    // after GAP_CYCLES consecutive idle cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_cnt  <= 2'd0;
            rx_b0   <= 8'h00;
            rx_b1   <= 8'h00;
            gap_cnt <= '0;
        end else if (i_uart_rx_valid) begin
            gap_cnt <= '0;
            case (rx_cnt)
                2'd0:    begin rx_b0 <= i_uart_rx_data; rx_cnt <= 2'd1; end
                2'd1:    begin rx_b1 <= i_uart_rx_data; rx_cnt <= 2'd2; end
                default: rx_cnt <= 2'd0;
            endcase
        end else if (rx_cnt != 2'd0) begin
            if (gap_cnt == GAP_LAST) begin
                rx_cnt  <= 2'd0;
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Result outputs: fb_match and telem_data hold between pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_fb_valid    <= 1'b0;
            o_fb_match    <= 1'b0;
            o_telem_valid <= 1'b0;
            o_telem_data  <= 24'h0;
        end else begin
            o_fb_valid    <= is_fb;
            o_telem_valid <= is_telem;
            if (is_fb) begin
                o_fb_match <= (rx_b1 == power_l) && (i_uart_rx_data[0] == sel_l);
            end
            if (is_telem) begin
                o_telem_data <= frame;
            end
        end
    end

    // Command FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            idx             <= 5'd0;
            fb_cnt          <= '0;
            sel_l           <= 1'b0;
            inh_l           <= 1'b0;
            phase_l         <= 48'h0;
            attn_l          <= 48'h0;
            power_l         <= 8'h00;
            o_uart_tx_valid <= 1'b0;
            o_uart_tx_data  <= 8'h00;
            o_fb_timeout    <= 1'b0;
        end else begin
            o_uart_tx_valid <= 1'b0;
            o_fb_timeout    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        sel_l   <= i_tx_rx_sel;
                        inh_l   <= i_soft_inhibit;
                        phase_l <= i_phase;
                        attn_l  <= i_attn;
                        power_l <= i_ch_power;
                        idx     <= 5'd0;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!i_uart_tx_active) begin
                        o_uart_tx_valid <= 1'b1;
                        o_uart_tx_data  <= cur_byte;
                        state           <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_uart_tx_done) begin
                        idx <= idx + 5'd1;
                        if (idx == LAST_IDX) begin
                            fb_cnt <= '0;
                            state  <= ST_WAIT_FB;
                        end else begin
                            state  <= ST_SEND;
                        end
                    end
                end
                default: begin
                    // A feedback frame landing on the timeout cycle takes priority.
                    if (is_fb) begin
                        state <= ST_IDLE;
                    end else if (fb_cnt == FB_LAST) begin
                        o_fb_timeout <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        fb_cnt <= fb_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
